// File: rtl/and_edge_counter.sv
// and_edge_counter: counts rising edges of and_in over fixed windows of
// WINDOW cycles and offers each window's count through a one-deep
// valid/ready report slot. A report that closes while the slot is still
// occupied and not being accepted is dropped and latches a sticky overflow.
module and_edge_counter #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CW     = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          and_in,
  output logic [CW-1:0] report_data,
  output logic          report_valid,
  input  logic          report_ready,
  output logic          overflow
);

  localparam int unsigned WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WW-1:0] WCNT_LAST = WW'(WINDOW - 1);
  localparam logic [CW-1:0] ACC_MAX   = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  logic          prev_q, prev_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] acc_q, acc_d;
  state_e        state_q, state_d;
  logic [CW-1:0] data_q, data_d;
  logic          overflow_q, overflow_d;

  logic          edge_hit;
  logic          close;
  logic [CW-1:0] close_value;

  // Edge detect, window counting, saturating accumulation and report slot.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    prev_d     = and_in;
    wcnt_d     = wcnt_q + WW'(1);
    acc_d      = acc_q;
    state_d    = state_q;
    data_d     = data_q;
    overflow_d = overflow_q;

    edge_hit    = and_in & ~prev_q;
    close       = (wcnt_q == WCNT_LAST);
    // Saturate instead of wrapping so a busy window reports the maximum.
    close_value = (edge_hit && acc_q != ACC_MAX) ? acc_q + CW'(1) : acc_q;

    if (close) begin
      wcnt_d = '0;
      // The edge of the close cycle is already folded into close_value.
      acc_d  = '0;
    end else begin
      acc_d  = close_value;
    end

    unique case (state_q)
      EMPTY: begin
        // report_ready has no meaning while nothing is offered.
        if (close) begin
          data_d  = close_value;
          state_d = FULL;
        end
      end
      FULL: begin
        if (close) begin
          if (report_ready) begin
            // Old report leaves as the new one arrives: no bubble on valid.
            data_d = close_value;
          end else begin
            // Slot still occupied: keep the pending report, drop the new one.
            overflow_d = 1'b1;
          end
        end else if (report_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State registers; synchronous reset overrides any close or handshake.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of statement order.
    if (reset) begin
      prev_q     <= 1'b0;
      wcnt_q     <= '0;
      acc_q      <= '0;
      state_q    <= EMPTY;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      wcnt_q     <= wcnt_d;
      acc_q      <= acc_d;
      state_q    <= state_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  assign report_data  = data_q;
  assign report_valid = (state_q == FULL);
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_and_edge_counter.sv
// Testbench for and_edge_counter: two instances (WINDOW=8 and WINDOW=40,
// both CW=4) share stimulus; a window-level reference model predicts every
// output each cycle, plus targeted checks for the documented scenarios.
module tb_and_edge_counter;

  localparam int SAT_MAX = 15;

  logic       clock = 1'b0;
  logic       reset;
  logic       and_in;
  logic       report_ready;
  logic [3:0] data_a, data_b;
  logic       valid_a, valid_b, ovf_a, ovf_b;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  and_edge_counter #(.WINDOW(8), .CW(4)) dut_a (
    .clock        (clock),
    .reset        (reset),
    .and_in       (and_in),
    .report_data  (data_a),
    .report_valid (valid_a),
    .report_ready (report_ready),
    .overflow     (ovf_a)
  );

  and_edge_counter #(.WINDOW(40), .CW(4)) dut_b (
    .clock        (clock),
    .reset        (reset),
    .and_in       (and_in),
    .report_data  (data_b),
    .report_valid (valid_b),
    .report_ready (report_ready),
    .overflow     (ovf_b)
  );

  // Reference model: per instance, cycles since reset, raw edge count of the
  // open window, and the contents of the one-deep report slot.
  int wlen[2] = '{8, 40};
  int m_cyc[2];
  int m_edges[2];
  bit m_prev[2];
  bit m_valid[2];
  bit m_ovf[2];
  int m_data[2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_cyc[k] = 0; m_edges[k] = 0; m_prev[k] = 0;
        m_valid[k] = 0; m_ovf[k] = 0; m_data[k] = 0;
      end else begin
        int val;
        if (and_in && !m_prev[k]) m_edges[k]++;
        if ((m_cyc[k] % wlen[k]) == wlen[k] - 1) begin
          val = (m_edges[k] > SAT_MAX) ? SAT_MAX : m_edges[k];
          m_edges[k] = 0;
          if (!m_valid[k] || report_ready) begin
            m_data[k]  = val;
            m_valid[k] = 1;
          end else begin
            m_ovf[k] = 1;
          end
        end else if (m_valid[k] && report_ready) begin
          m_valid[k] = 0;
        end
        m_prev[k] = and_in;
        m_cyc[k]++;
      end
    end
  endtask

  task automatic compare();
    check("model_valid_a", 32'(valid_a), 32'(m_valid[0]));
    check("model_data_a",  32'(data_a),  32'(m_data[0]));
    check("model_ovf_a",   32'(ovf_a),   32'(m_ovf[0]));
    check("model_valid_b", 32'(valid_b), 32'(m_valid[1]));
    check("model_data_b",  32'(data_b),  32'(m_data[1]));
    check("model_ovf_b",   32'(ovf_b),   32'(m_ovf[1]));
  endtask

  // One clock cycle: drive at negedge, model on posedge, compare at negedge.
  task automatic cyc(input bit r, input bit a, input bit rd);
    reset        = r;
    and_in       = a;
    report_ready = rd;
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare();
  endtask

  initial begin
    reset = 1'b1; and_in = 1'b0; report_ready = 1'b0;

    // Reset held 3 cycles with and_in toggling.
    for (int i = 0; i < 3; i++) cyc(1'b1, (i % 2) == 0, 1'b1);
    check("rst_data_a",  32'(data_a),  0);
    check("rst_valid_a", 32'(valid_a), 0);
    check("rst_ovf_a",   32'(ovf_a),   0);
    check("rst_valid_b", 32'(valid_b), 0);

    // Toggling input 1,0,1,0... from the first post-reset cycle, ready=1.
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, (i % 2) == 0, 1'b1);
      if (i == 6)  check("toggle_no_early_close", 32'(valid_a), 0);
      if (i == 7) begin
        check("toggle_first_valid", 32'(valid_a), 1);
        check("toggle_first_data",  32'(data_a),  4);
      end
      if (i == 15) check("toggle_second_data", 32'(data_a), 4);
      if (i == 39) begin
        check("sat_valid", 32'(valid_b), 1);
        check("sat_data",  32'(data_b),  15);
      end
    end

    // Constant input: first window sees one edge, later windows none.
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      if (i == 7)  check("const_first", 32'(data_a), 1);
      if (i == 15) check("const_second", 32'(data_a), 0);
      if (i == 23) check("const_third_valid", 32'(valid_a), 1);
    end

    // Backpressure: ready low for 20 cycles, then one handshake.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, (i % 2) == 0 || i >= 8, 1'b0);
      if (i == 7)  check("bp_first_data", 32'(data_a), 4);
      if (i == 14) check("bp_ovf_before", 32'(ovf_a), 0);
      if (i == 15) check("bp_ovf_after",  32'(ovf_a), 1);
      if (i == 19) begin
        check("bp_held_data",  32'(data_a),  4);
        check("bp_held_valid", 32'(valid_a), 1);
      end
    end
    cyc(1'b0, 1'b0, 1'b1);
    check("bp_accepted_valid", 32'(valid_a), 0);
    check("bp_ovf_sticky",     32'(ovf_a),   1);
    cyc(1'b0, 1'b0, 1'b0);
    check("bp_single_handshake", 32'(valid_a), 0);

    // Accept on the close cycle while FULL: valid stays, data updates.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, (i < 8) ? ((i % 2) == 0) : ((i % 4) < 2), i == 15);
      if (i == 7) check("sim_first_data", 32'(data_a), 4);
      if (i == 15) begin
        check("sim_valid_kept", 32'(valid_a), 1);
        check("sim_new_data",   32'(data_a),  2);
        check("sim_no_ovf",     32'(ovf_a),   0);
      end
    end

    // Reset at wcnt=5 discards the partial count.
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    check("midrst_valid", 32'(valid_a), 0);
    check("midrst_data",  32'(data_a),  0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, i < 3, 1'b1);
      if (i == 7) check("midrst_post_count", 32'(data_a), 1);
    end

    // Randomised traffic with phases of light and heavy backpressure.
    for (int i = 0; i < 3000; i++) begin
      bit r, a, rd;
      r  = ($urandom_range(0, 299) == 0);
      a  = $urandom_range(0, 1) == 1;
      rd = ((i % 600) < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc(r, a, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
